// File: rtl/systolic_feeder.sv
// Operand feeder for an N x N output-stationary systolic array: holds A and B,
// then streams them skewed into the left/top edges and pulses done once the last products settle.
module systolic_feeder #(
  parameter int DATA_SIZE = 4,
  parameter int N         = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load_valid,
  input  logic                      load_sel,
  input  logic [$clog2(N)-1:0]      load_row,
  input  logic [$clog2(N)-1:0]      load_col,
  input  logic [DATA_SIZE-1:0]      load_data,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      array_clr,
  output logic [N*DATA_SIZE-1:0]    a_out,
  output logic [N*DATA_SIZE-1:0]    b_out
);

  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = $clog2(2 * N);
  localparam logic [CNT_W-1:0] STREAM_LAST = CNT_W'(2 * N - 2);
  localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(N - 2);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  logic [DATA_SIZE-1:0] mem_a [N][N];
  logic [DATA_SIZE-1:0] mem_b [N][N];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Operand storage is only writable while idle so a pass always sees a stable matrix.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_a <= '{default: '0};
      mem_b <= '{default: '0};
    end else if (load_valid && (state == IDLE)) begin
      if (load_sel) begin
        mem_b[load_row][load_col] <= load_data;
      end else begin
        mem_a[load_row][load_col] <= load_data;
      end
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    busy       = 1'b0;
    done       = 1'b0;
    array_clr  = 1'b0;
    a_out      = '0;
    b_out      = '0;

    unique case (state)
      IDLE: begin
        if (start) state_next = CLEAR;
      end
      CLEAR: begin
        state_next = STREAM;
        cnt_next   = '0;
      end
      STREAM: begin
        if (cnt == STREAM_LAST) begin
          state_next = DRAIN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          state_next = DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    // Reset holds the PE array cleared and silences every edge operand.
    if (reset) begin
      array_clr = 1'b1;
    end else begin
      busy      = (state != IDLE);
      done      = (state == DONE);
      array_clr = (state == CLEAR);
      if (state == STREAM) begin
        // Row i / column j is delayed by i / j cycles so matching k terms meet in PE(i,j).
        for (int i = 0; i < N; i++) begin
          if ((int'(cnt) >= i) && (int'(cnt) - i < N)) begin
            a_out[i*DATA_SIZE +: DATA_SIZE] = mem_a[IDX_W'(i)][IDX_W'(int'(cnt) - i)];
            b_out[i*DATA_SIZE +: DATA_SIZE] = mem_b[IDX_W'(int'(cnt) - i)][IDX_W'(i)];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized self-checking bench for systolic_feeder: a reference matrix store plus an
// abstract output-stationary PE array model rebuilds C from the observed edge streams.
module tb_systolic_feeder;

  localparam int DATA_SIZE = 4;
  localparam int N         = 4;
  localparam int IW        = $clog2(N);
  localparam int W         = N * DATA_SIZE;
  localparam int CAPN      = 3 * N - 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 load_valid;
  logic                 load_sel;
  logic [IW-1:0]        load_row;
  logic [IW-1:0]        load_col;
  logic [DATA_SIZE-1:0] load_data;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 array_clr;
  logic [W-1:0]         a_out;
  logic [W-1:0]         b_out;

  int vectors     = 0;
  int miscompares = 0;

  int ma [N][N];
  int mb [N][N];
  int cap_a [CAPN][N];
  int cap_b [CAPN][N];
  int cc [N][N];
  int pc [N][N];

  always #5 clk = ~clk;

  systolic_feeder #(.DATA_SIZE(DATA_SIZE), .N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .load_valid(load_valid),
    .load_sel  (load_sel),
    .load_row  (load_row),
    .load_col  (load_col),
    .load_data (load_data),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .array_clr (array_clr),
    .a_out     (a_out),
    .b_out     (b_out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int slice(input logic [W-1:0] v, input int i);
    return int'(v[i*DATA_SIZE +: DATA_SIZE]);
  endfunction

  // Expected edge operands at stream index t (DRAIN cycles follow with zeros).
  function automatic int exp_a(input int t, input int i);
    if (t <= 2*N-2 && t-i >= 0 && t-i < N) return ma[i][t-i];
    return 0;
  endfunction

  function automatic int exp_b(input int t, input int j);
    if (t <= 2*N-2 && t-j >= 0 && t-j < N) return mb[t-j][j];
    return 0;
  endfunction

  task automatic load_model();
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        for (int s = 0; s < 2; s++) begin
          load_valid = 1'b1;
          load_sel   = s[0];
          load_row   = IW'(r);
          load_col   = IW'(c);
          load_data  = DATA_SIZE'(s == 1 ? mb[r][c] : ma[r][c]);
          step();
        end
      end
    end
    load_valid = 1'b0;
  endtask

  task automatic randomize_model();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma[r][c] = int'($urandom_range(0, 15));
        mb[r][c] = int'($urandom_range(0, 15));
      end
  endtask

  task automatic model_product();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        pc[i][j] = 0;
        for (int k = 0; k < N; k++) pc[i][j] += ma[i][k] * mb[k][j];
      end
  endtask

  // PE(i,j) sees row i's operand j cycles late and column j's operand i cycles late.
  task automatic compute_c();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        cc[i][j] = 0;
        for (int s = 0; s < CAPN + 2*N; s++) begin
          if (s-j >= 0 && s-j < CAPN && s-i >= 0 && s-i < CAPN)
            cc[i][j] += cap_a[s-j][i] * cap_b[s-i][j];
        end
      end
  endtask

  // Starts a pass from IDLE and follows it until done (bounded). Optional element load in the
  // start cycle, optional load+start injection at cycle inj_cyc while busy.
  task automatic run_pass(input bit ld, input bit lsel, input int lr, input int lc, input int lv,
                          input int inj_cyc,
                          output int lat, output int clr_cnt, output int done_cnt, output int anomaly);
    start = 1'b1;
    if (ld) begin
      load_valid = 1'b1;
      load_sel   = lsel;
      load_row   = IW'(lr);
      load_col   = IW'(lc);
      load_data  = DATA_SIZE'(lv);
      if (lsel) mb[lr][lc] = lv; else ma[lr][lc] = lv;
    end
    step();
    start = 1'b0;
    load_valid = 1'b0;
    lat = -1; clr_cnt = 0; done_cnt = 0; anomaly = 0;
    for (int t = 0; t < CAPN; t++)
      for (int i = 0; i < N; i++) begin cap_a[t][i] = 0; cap_b[t][i] = 0; end
    for (int cyc = 1; cyc <= 6*N; cyc++) begin
      if (array_clr) clr_cnt++;
      if (!busy) anomaly++;
      if (done) begin
        done_cnt++;
        if (lat < 0) lat = cyc;
      end
      if ((cyc == 1 || done) && (a_out !== '0 || b_out !== '0)) anomaly++;
      if (cyc >= 2 && cyc - 2 < CAPN)
        for (int i = 0; i < N; i++) begin
          cap_a[cyc-2][i] = slice(a_out, i);
          cap_b[cyc-2][i] = slice(b_out, i);
        end
      if (cyc == inj_cyc) begin
        start = 1'b1; load_valid = 1'b1; load_sel = 1'b0;
        load_row = '0; load_col = '0; load_data = DATA_SIZE'(ma[0][0] ^ 15);
      end else begin
        start = 1'b0; load_valid = 1'b0;
      end
      if (lat >= 0) break;
      step();
    end
    start = 1'b0;
    load_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    repeat (3) step();
    vectors += 5;
    if (busy !== 1'b0)      begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    if (done !== 1'b0)      begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    if (array_clr !== 1'b1) begin miscompares++; $display("FAIL reset_clr got %b want 1", array_clr); end
    if (a_out !== '0)       begin miscompares++; $display("FAIL reset_a got %h want 0", a_out); end
    if (b_out !== '0)       begin miscompares++; $display("FAIL reset_b got %h want 0", b_out); end
    start = 1'b0;
    reset = 1'b0;
    #1;
    vectors += 2;
    if (array_clr !== 1'b0) begin miscompares++; $display("FAIL idle_clr got %b want 0", array_clr); end
    if (busy !== 1'b0)      begin miscompares++; $display("FAIL idle_busy got %b want 0", busy); end
    step();
  endtask

  task automatic test_identity();
    int lat, clr, dn, an;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma[r][c] = (r == c) ? 1 : 0;
        mb[r][c] = r*4 + c;
      end
    load_model();
    run_pass(0, 0, 0, 0, 0, 0, lat, clr, dn, an);
    compute_c();
    vectors += 5;
    if (lat !== 3*N) begin miscompares++; $display("FAIL ident_latency got %0d want %0d", lat, 3*N); end
    if (clr !== 1)   begin miscompares++; $display("FAIL ident_clr_cycles got %0d want 1", clr); end
    if (dn !== 1)    begin miscompares++; $display("FAIL ident_done_count got %0d want 1", dn); end
    if (an !== 0)    begin miscompares++; $display("FAIL ident_anomalies got %0d want 0", an); end
    if (cc[3][3] !== 15) begin miscompares++; $display("FAIL ident_c33 got %0d want 15", cc[3][3]); end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        vectors++;
        if (cc[i][j] !== i*4 + j) begin
          miscompares++; $display("FAIL ident_c[%0d][%0d] got %0d want %0d", i, j, cc[i][j], i*4 + j);
        end
      end
  endtask

  task automatic test_skew();
    int lat, clr, dn, an;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma[r][c] = r + 1;
        mb[r][c] = r + 1;
      end
    load_model();
    run_pass(0, 0, 0, 0, 0, 0, lat, clr, dn, an);
    for (int i = 0; i < N; i++) begin
      vectors += 2;
      if (cap_a[3][i] !== i + 1) begin miscompares++; $display("FAIL skew_a slice %0d got %0d want %0d", i, cap_a[3][i], i + 1); end
      if (cap_b[3][i] !== 4 - i) begin miscompares++; $display("FAIL skew_b slice %0d got %0d want %0d", i, cap_b[3][i], 4 - i); end
    end
  endtask

  task automatic test_max();
    int lat, clr, dn, an;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin ma[r][c] = 15; mb[r][c] = 15; end
    load_model();
    run_pass(0, 0, 0, 0, 0, 0, lat, clr, dn, an);
    compute_c();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        vectors++;
        if (cc[i][j] !== 900) begin miscompares++; $display("FAIL max_c[%0d][%0d] got %0d want 900", i, j, cc[i][j]); end
      end
  endtask

  task automatic test_random();
    int lat, clr, dn, an;
    for (int it = 0; it < 3; it++) begin
      randomize_model();
      load_model();
      run_pass(0, 0, 0, 0, 0, 0, lat, clr, dn, an);
      model_product();
      compute_c();
      vectors++;
      if (lat !== 3*N) begin miscompares++; $display("FAIL rand_latency got %0d want %0d", lat, 3*N); end
      for (int t = 0; t < CAPN; t++)
        for (int i = 0; i < N; i++) begin
          vectors++;
          if (cap_a[t][i] !== exp_a(t, i) || cap_b[t][i] !== exp_b(t, i)) begin
            miscompares++;
            $display("FAIL rand_stream t=%0d slice=%0d a got %0d want %0d, b got %0d want %0d",
                     t, i, cap_a[t][i], exp_a(t, i), cap_b[t][i], exp_b(t, i));
          end
        end
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          vectors++;
          if (cc[i][j] !== pc[i][j]) begin
            miscompares++; $display("FAIL rand_c[%0d][%0d] got %0d want %0d", i, j, cc[i][j], pc[i][j]);
          end
        end
    end
  endtask

  task automatic test_busy_protect();
    int lat, clr, dn, an, extra;
    randomize_model();
    load_model();
    model_product();
    run_pass(0, 0, 0, 0, 0, 4, lat, clr, dn, an);
    vectors += 2;
    if (lat !== 3*N) begin miscompares++; $display("FAIL busy_latency got %0d want %0d", lat, 3*N); end
    if (dn !== 1)    begin miscompares++; $display("FAIL busy_done_count got %0d want 1", dn); end
    extra = 0;
    repeat (3*N + 4) begin
      if (busy || done) extra++;
      step();
    end
    vectors++;
    if (extra !== 0) begin miscompares++; $display("FAIL busy_second_pass active cycles got %0d want 0", extra); end
    run_pass(0, 0, 0, 0, 0, 0, lat, clr, dn, an);
    compute_c();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        vectors++;
        if (cc[i][j] !== pc[i][j]) begin
          miscompares++; $display("FAIL busy_storage c[%0d][%0d] got %0d want %0d", i, j, cc[i][j], pc[i][j]);
        end
      end
  endtask

  task automatic test_reset_mid();
    int lat, clr, dn, an, seen_done;
    randomize_model();
    load_model();
    start = 1'b1;
    step();
    start = 1'b0;
    seen_done = 0;
    repeat (3) begin
      if (done) seen_done++;
      step();
    end
    reset = 1'b1;
    #1;
    vectors += 3;
    if (busy !== 1'b0)      begin miscompares++; $display("FAIL mid_reset_busy got %b want 0", busy); end
    if (array_clr !== 1'b1) begin miscompares++; $display("FAIL mid_reset_clr got %b want 1", array_clr); end
    if (a_out !== '0 || b_out !== '0) begin miscompares++; $display("FAIL mid_reset_ops got %h/%h want 0", a_out, b_out); end
    step();
    reset = 1'b0;
    #1;
    if (done) seen_done++;
    vectors += 2;
    if (busy !== 1'b0)  begin miscompares++; $display("FAIL mid_idle_busy got %b want 0", busy); end
    if (seen_done !== 0) begin miscompares++; $display("FAIL mid_done_pulses got %0d want 0", seen_done); end
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin ma[r][c] = 0; mb[r][c] = 0; end
    run_pass(0, 0, 0, 0, 0, 0, lat, clr, dn, an);
    vectors += 2;
    if (lat !== 3*N) begin miscompares++; $display("FAIL mid_restart_latency got %0d want %0d", lat, 3*N); end
    if (an !== 0)    begin miscompares++; $display("FAIL mid_restart_anomalies got %0d want 0", an); end
    for (int t = 0; t < CAPN; t++)
      for (int i = 0; i < N; i++) begin
        vectors++;
        if (cap_a[t][i] !== 0 || cap_b[t][i] !== 0) begin
          miscompares++; $display("FAIL mid_cleared t=%0d slice=%0d got %0d/%0d want 0", t, i, cap_a[t][i], cap_b[t][i]);
        end
      end
  endtask

  task automatic test_back_to_back();
    int lat, clr, dn, an, nv;
    randomize_model();
    load_model();
    run_pass(0, 0, 0, 0, 0, 0, lat, clr, dn, an);
    nv = (mb[2][1] + 1) % 16;
    run_pass(1, 1, 2, 1, nv, 0, lat, clr, dn, an);
    model_product();
    compute_c();
    vectors += 3;
    if (lat !== 3*N) begin miscompares++; $display("FAIL b2b_latency got %0d want %0d", lat, 3*N); end
    if (clr !== 1)   begin miscompares++; $display("FAIL b2b_clr_cycles got %0d want 1", clr); end
    if (dn !== 1)    begin miscompares++; $display("FAIL b2b_done_count got %0d want 1", dn); end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        vectors++;
        if (cc[i][j] !== pc[i][j]) begin
          miscompares++; $display("FAIL b2b_c[%0d][%0d] got %0d want %0d", i, j, cc[i][j], pc[i][j]);
        end
      end
  endtask

  initial begin
    reset      = 1'b1;
    load_valid = 1'b0;
    load_sel   = 1'b0;
    load_row   = '0;
    load_col   = '0;
    load_data  = '0;
    start      = 1'b0;
    test_reset();
    test_identity();
    test_skew();
    test_max();
    test_random();
    test_busy_protect();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
